// File: rtl/score_bcd_unit_if.sv
// Event inputs, score outputs and seven-segment drives of the score/BCD unit.
// The controller (master) drives events; the score unit (slave) returns results.
interface score_bcd_unit_if;
  logic        clear_valid;
  logic [2:0]  clear_count;
  logic        game_over;
  logic        new_game;
  logic        show_best;
  logic [23:0] score_bcd;
  logic [23:0] best_bcd;
  logic        busy;
  logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;

  modport master (
    output clear_valid, clear_count, game_over, new_game, show_best,
    input  score_bcd, best_bcd, busy, HEX0, HEX1, HEX2, HEX3, HEX4, HEX5
  );

  modport slave (
    input  clear_valid, clear_count, game_over, new_game, show_best,
    output score_bcd, best_bcd, busy, HEX0, HEX1, HEX2, HEX3, HEX4, HEX5
  );
endinterface

// File: rtl/score_bcd_unit.sv
// Score accumulator: pending points are folded into a 6-digit packed BCD score one
// digit per cycle; tracks the best score and drives six active-low 7-segment digits.
module score_bcd_seg #(
  parameter bit BLANK_LEAD = 1'b1
) (
  input  logic [3:0] digit,
  input  logic       upper_zero,
  output logic [6:0] seg
);
  always_comb begin
    case (digit)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = 7'b1111111;
    endcase
    if (BLANK_LEAD && upper_zero && (digit == 4'd0)) seg = 7'b1111111;
  end
endmodule

module score_bcd_unit #(
  parameter logic [4:0] PTS_1      = 5'd1,
  parameter logic [4:0] PTS_2      = 5'd3,
  parameter logic [4:0] PTS_3      = 5'd5,
  parameter logic [4:0] PTS_4      = 5'd8,
  parameter bit         BLANK_LEAD = 1'b1
) (
  input  logic           CLOCK_50,
  input  logic           reset,
  score_bcd_unit_if.slave bus
);
  localparam int          NUM_DIGITS = 6;
  localparam logic [23:0] SAT_SCORE  = 24'h999999;

  typedef enum logic {IDLE, ADD} state_t;

  state_t      state_q, state_d;
  logic [23:0] score_q, score_d, best_q, best_d, work_q, work_d;
  logic [4:0]  pend_q, pend_d;
  logic        flag_q, flag_d, carry_q, carry_d;
  logic [2:0]  idx_q, idx_d;
  logic [3:0]  add0_q, add0_d, add1_q, add1_d;
  logic [NUM_DIGITS-1:0][6:0] hex_q, hex_d;

  logic        load;
  logic [4:0]  pts;
  logic [5:0]  pend_sum;
  logic [3:0]  cur_dig, addend;
  logic [4:0]  dsum, dsum_adj;
  logic [7:0]  pend_bcd;
  logic [23:0] disp_src;
  logic [NUM_DIGITS-1:0] upper_zero;

  // Pending is at most 31, so the tens digit never exceeds 3.
  function automatic logic [7:0] bin_to_bcd(input logic [4:0] b);
    logic [4:0] u;
    logic [3:0] t;
    if (b >= 5'd30)      begin t = 4'd3; u = b - 5'd30; end
    else if (b >= 5'd20) begin t = 4'd2; u = b - 5'd20; end
    else if (b >= 5'd10) begin t = 4'd1; u = b - 5'd10; end
    else                 begin t = 4'd0; u = b;         end
    return {t, u[3:0]};
  endfunction

  always_comb begin
    case (bus.clear_count)
      3'd1:    pts = PTS_1;
      3'd2:    pts = PTS_2;
      3'd3:    pts = PTS_3;
      3'd4:    pts = PTS_4;
      default: pts = 5'd0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    score_d = score_q;
    best_d  = best_q;
    work_d  = work_q;
    flag_d  = flag_q | bus.game_over;
    carry_d = carry_q;
    idx_d   = idx_q;
    add0_d  = add0_q;
    add1_d  = add1_q;

    load     = (state_q == IDLE) && (pend_q != 5'd0);
    pend_sum = {1'b0, load ? 5'd0 : pend_q} + {1'b0, bus.clear_valid ? pts : 5'd0};
    pend_d   = (pend_sum > 6'd31) ? 5'd31 : pend_sum[4:0];
    pend_bcd = bin_to_bcd(pend_q);

    cur_dig  = work_q[{idx_q, 2'b00} +: 4];
    addend   = (idx_q == 3'd0) ? add0_q : (idx_q == 3'd1) ? add1_q : 4'd0;
    dsum     = {1'b0, cur_dig} + {1'b0, addend} + {4'd0, carry_q};
    dsum_adj = dsum - 5'd10;

    case (state_q)
      IDLE: begin
        if (load) begin
          work_d  = score_q;
          add0_d  = pend_bcd[3:0];
          add1_d  = pend_bcd[7:4];
          idx_d   = 3'd0;
          carry_d = 1'b0;
          state_d = ADD;
        end else if (flag_q) begin
          // Game-over is only serviced once the score has fully settled.
          if (score_q > best_q) best_d = score_q;
          flag_d = 1'b0;
        end
      end
      ADD: begin
        if (dsum > 5'd9) begin
          work_d[{idx_q, 2'b00} +: 4] = dsum_adj[3:0];
          carry_d = 1'b1;
        end else begin
          work_d[{idx_q, 2'b00} +: 4] = dsum[3:0];
          carry_d = 1'b0;
        end
        if (idx_q == 3'd5) begin
          score_d = carry_d ? SAT_SCORE : work_d;
          state_d = IDLE;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // New game drops everything in flight, but still banks an outstanding game-over.
    if (bus.new_game) begin
      best_d  = ((flag_q || bus.game_over) && (score_q > best_q)) ? score_q : best_q;
      score_d = 24'h0;
      pend_d  = 5'd0;
      flag_d  = 1'b0;
      state_d = IDLE;
      idx_d   = 3'd0;
      carry_d = 1'b0;
    end
  end

  always_comb begin
    disp_src = bus.show_best ? best_q : score_q;
    upper_zero[NUM_DIGITS-1] = 1'b1;
    for (int k = NUM_DIGITS - 2; k >= 0; k--)
      upper_zero[k] = upper_zero[k+1] && (disp_src[(k+1)*4 +: 4] == 4'd0);
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_seg
    score_bcd_seg #(.BLANK_LEAD(BLANK_LEAD)) u_seg (
      .digit      (disp_src[g*4 +: 4]),
      .upper_zero ((g == 0) ? 1'b0 : upper_zero[g]),
      .seg        (hex_d[g])
    );
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= IDLE;
      score_q <= 24'h0;
      best_q  <= 24'h0;
      work_q  <= 24'h0;
      pend_q  <= 5'd0;
      flag_q  <= 1'b0;
      carry_q <= 1'b0;
      idx_q   <= 3'd0;
      add0_q  <= 4'd0;
      add1_q  <= 4'd0;
      hex_q[0] <= 7'b1000000;
      for (int k = 1; k < NUM_DIGITS; k++)
        hex_q[k] <= BLANK_LEAD ? 7'b1111111 : 7'b1000000;
    end else begin
      state_q <= state_d;
      score_q <= score_d;
      best_q  <= best_d;
      work_q  <= work_d;
      pend_q  <= pend_d;
      flag_q  <= flag_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      add0_q  <= add0_d;
      add1_q  <= add1_d;
      hex_q   <= hex_d;
    end
  end

  assign bus.score_bcd = score_q;
  assign bus.best_bcd  = best_q;
  assign bus.busy      = (state_q != IDLE) || (pend_q != 5'd0);
  assign bus.HEX0      = hex_q[0];
  assign bus.HEX1      = hex_q[1];
  assign bus.HEX2      = hex_q[2];
  assign bus.HEX3      = hex_q[3];
  assign bus.HEX4      = hex_q[4];
  assign bus.HEX5      = hex_q[5];
endmodule
